vector_output_tracer: RTL
=========================

Name: vector_output_tracer

Overview:
- Synthesizable, parametrised output-capture unit for the vector CPU.
- Samples the CPU result bus (VECTOR_SIZE lanes × DATA_WIDTH) under a selectable capture mode and timestamps each sample with a cycle count.
- Buffers samples in a FIFO and drains them over a valid/ready stream to a host or UART bridge.
- Bounds each run to a programmable cycle limit and reports completion, overflow and dropped-sample count.

Parameters:
- DATA_WIDTH, 19, bits per lane.
- VECTOR_SIZE, 6, lanes per sample.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- TS_WIDTH, 16, timestamp/cycle-counter width.
- DROP_WIDTH, 8, dropped-sample counter width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- cycle_limit  in  TS_WIDTH  run length in cycles; sampled on start.
- mode  in  2  capture mode: 0 OFF, 1 ON_FLAG, 2 EVERY, 3 ON_CHANGE; sampled on start.
- lane_mask  in  VECTOR_SIZE  1 = lane captured, 0 = lane forced to zero; sampled on start.
- out  in  VECTOR_SIZE*DATA_WIDTH  CPU result bus; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- outFlag  in  1  CPU output-valid strobe.
- trace_data  out  VECTOR_SIZE*DATA_WIDTH  head-of-FIFO sample.
- trace_ts  out  TS_WIDTH  cycle index of the head sample.
- trace_valid  out  1  head entry is valid.
- trace_ready  in  1  consumer accepts the head entry.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a capture was dropped during this run.
- dropped  out  DROP_WIDTH  saturating count of dropped captures.
- busy  out  1  state is RUN or DRAIN.
- run_done  out  1  state is DONE.

Behaviour:
- Reset values: state IDLE. trace_valid, busy, run_done, overflow are 0. fill_level, dropped, trace_ts, trace_data, cycle counter and last-value register are 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with start=1 → RUN.
  - Latches cycle_limit, mode and lane_mask.
  - Clears the cycle counter, overflow, dropped and the change-detect "first" flag.
  - The FIFO is not flushed; leftover entries remain drainable.
- RUN:
  - The cycle counter is the timestamp of the current cycle and increments every cycle.
  - When counter == limit-1 → DRAIN next cycle; exactly `limit` cycles are sampled.
  - limit == 0 → RUN lasts one cycle, treated as a limit of 1.
- DRAIN → DONE in the cycle after the FIFO becomes empty (fill_level==0 and no pending push).
- start is ignored in RUN and DRAIN.
- Capture condition, evaluated in RUN only, on masked data m = out with unmasked lanes zeroed:
  - OFF: never capture.
  - ON_FLAG: capture when outFlag=1.
  - EVERY: capture every cycle.
  - ON_CHANGE: capture when outFlag=1 and (first sample of the run, or m != last captured m). The last-value register updates only on a successful push.
- Push: the pair {m, counter} is written at the clock edge. trace_valid reflects the entry the next cycle (latency 1), matching the FIFO show-ahead behaviour.
- Pop: occurs when trace_valid && trace_ready. trace_data and trace_ts are stable while trace_valid=1 and trace_ready=0.
- Full FIFO:
  - Capture without a simultaneous pop is dropped.
  - overflow is set; dropped increments, saturating at all-ones.
  - Simultaneous pop and capture when full is accepted; occupancy is unchanged.
- Empty FIFO: trace_ready is ignored; no underflow; pointers are unchanged.
- Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- Reset asserted mid-run or mid-drain: everything returns to reset values the next edge, including the FIFO contents (pointers cleared).

Decomposition:
- Package vector_trace_pkg holds:
  - enum trace_state_t {IDLE, RUN, DRAIN, DONE};
  - enum trace_mode_t {MODE_OFF, MODE_ON_FLAG, MODE_EVERY, MODE_ON_CHANGE};
  - function lane_mask_apply.
- Sub-module trace_fifo: parametrised synchronous show-ahead FIFO.
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, din, dout, count, full, empty.
  - Simultaneous push/pop is legal when full.
- The top level contains only the FSM, counters, mask, change detect and drop logic.

Test Plan:
- Reset, then start with mode=ON_FLAG, limit=10, mask=all-ones; outFlag high at cycles 2 and 5 with out=lane pattern k+1; trace_ready=1 → two beats, ts=2 and 5 with data matching; run_done rises after DRAIN; overflow=0.
- Mode EVERY, limit=40, DEPTH=16, trace_ready=0 → fill_level saturates at 16, overflow=1, dropped=24. Then raise trace_ready → 16 beats with ts 0..15, then DONE.
- Mode ON_CHANGE, outFlag=1 for 6 cycles with values A,A,B,B,B,A → three beats (A@0, B@2, A@5).
- lane_mask=6'b000101 with all lanes = 19'h7FFFF → captured beat has lanes 0 and 2 = 7FFFF and the other lanes = 0.
- FIFO full while a capture and a pop occur in the same cycle → capture accepted, fill_level stays 16, dropped unchanged.
- Assert reset during RUN with 5 entries buffered → the next cycle shows state IDLE, trace_valid=0, fill_level=0, dropped=0. A subsequent start runs normally.

Source files
------------

// File: rtl/vector_trace_pkg.sv
// Shared types and the lane-masking helper for the vector output tracer.
package vector_trace_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} trace_state_t;

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_ON_FLAG,
        MODE_EVERY,
        MODE_ON_CHANGE
    } trace_mode_t;

    // Upper bounds of the generic masking helper; callers zero-extend into
    // these widths and truncate the result back to their own bus width.
    localparam int MAX_LANES = 32;
    localparam int MAX_BUS_W = 512;

    // Zero every lane whose mask bit is clear. Lane k occupies bits
    // [k*lane_width +: lane_width].
    function automatic logic [MAX_BUS_W-1:0] lane_mask_apply(
        input logic [MAX_BUS_W-1:0] data,
        input logic [MAX_LANES-1:0] mask,
        input int                   lane_width
    );
        logic [MAX_BUS_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_BUS_W; i++) begin
            if ((i / lane_width) < MAX_LANES && mask[i / lane_width]) begin
                res[i] = data[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vector_output_tracer_if.sv
// Trace stream from the tracer (master) to a host or UART bridge (slave).
interface vector_output_tracer_if #(
    parameter int DATA_W = 114,
    parameter int TS_W   = 16
);
    logic [DATA_W-1:0] trace_data;
    logic [TS_W-1:0]   trace_ts;
    logic              trace_valid;
    logic              trace_ready;

    modport master (
        output trace_data,
        output trace_ts,
        output trace_valid,
        input  trace_ready
    );

    modport slave (
        input  trace_data,
        input  trace_ts,
        input  trace_valid,
        output trace_ready
    );
endinterface

// File: rtl/vector_output_tracer_fifo.sv
// Synchronous show-ahead FIFO; dout presents the head entry, zero when empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers is enough
    // because nothing is ever read from an entry that was not written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    assign dout  = empty ? '0 : mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/vector_output_tracer.sv
// Captures masked, timestamped samples of the vector CPU result bus into a
// FIFO and drains them over a valid/ready stream, bounded by a cycle limit.
module vector_output_tracer
    import vector_trace_pkg::*;
#(
    parameter int DATA_WIDTH  = 19,
    parameter int VECTOR_SIZE = 6,
    parameter int DEPTH       = 16,
    parameter int TS_WIDTH    = 16,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [TS_WIDTH-1:0]               cycle_limit,
    input  logic [1:0]                        mode,
    input  logic [VECTOR_SIZE-1:0]            lane_mask,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] out,
    input  logic                              outFlag,
    vector_output_tracer_if.master            trace,
    output logic [$clog2(DEPTH):0]            fill_level,
    output logic                              overflow,
    output logic [DROP_WIDTH-1:0]             dropped,
    output logic                              busy,
    output logic                              run_done
);
    localparam int BUS_W   = VECTOR_SIZE * DATA_WIDTH;
    localparam int ENTRY_W = BUS_W + TS_WIDTH;

    trace_state_t           state_q;
    trace_mode_t            mode_q;
    logic [TS_WIDTH-1:0]    limit_q;
    logic [TS_WIDTH-1:0]    cnt_q;
    logic [TS_WIDTH-1:0]    cnt_d;
    logic [VECTOR_SIZE-1:0] mask_q;
    logic [BUS_W-1:0]       last_q;
    logic                   seen_q;
    logic                   overflow_q;
    logic [DROP_WIDTH-1:0]  dropped_q;
    logic [DROP_WIDTH-1:0]  dropped_d;
    logic                   busy_q;
    logic                   run_done_q;

    logic [BUS_W-1:0]       masked;
    logic                   capture;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   run_last;

    logic [ENTRY_W-1:0]     fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign masked = BUS_W'(lane_mask_apply(MAX_BUS_W'(out), MAX_LANES'(mask_q), DATA_WIDTH));

    // A limit of zero behaves like a limit of one.
    assign run_last  = (limit_q == '0) || (cnt_q == limit_q - TS_WIDTH'(1));
    assign cnt_d     = cnt_q + TS_WIDTH'(1);
    assign dropped_d = (dropped_q == '1) ? dropped_q : dropped_q + DROP_WIDTH'(1);

    always_comb begin
        // NOTE: default first so no path leaves capture unassigned (no latch).
        capture = 1'b0;
        if (state_q == RUN) begin
            unique case (mode_q)
                MODE_ON_FLAG:   capture = outFlag;
                MODE_EVERY:     capture = 1'b1;
                MODE_ON_CHANGE: capture = outFlag && (!seen_q || masked != last_q);
                default:        capture = 1'b0;
            endcase
        end
    end

    assign pop  = trace.trace_ready && !fifo_empty;
    assign push = capture && (!fifo_full || pop);
    assign drop = capture && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_OFF;
            limit_q    <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            last_q     <= '0;
            seen_q     <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            busy_q     <= 1'b0;
            run_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        run_done_q <= 1'b0;
                        limit_q    <= cycle_limit;
                        mode_q     <= trace_mode_t'(mode);
                        mask_q     <= lane_mask;
                        cnt_q      <= '0;
                        overflow_q <= 1'b0;
                        dropped_q  <= '0;
                        seen_q     <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (run_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    // Captures stop in DRAIN, so an empty FIFO has nothing pending.
                    if (fifo_empty) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        run_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
                dropped_q  <= dropped_d;
            end
            if (push) begin
                last_q <= masked;
                seen_q <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (trace.trace_ready),
        .din   ({masked, cnt_q}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trace.trace_data  = fifo_dout[TS_WIDTH +: BUS_W];
    assign trace.trace_ts    = fifo_dout[TS_WIDTH-1:0];
    assign trace.trace_valid = !fifo_empty;

    assign fill_level = fifo_count;
    assign overflow   = overflow_q;
    assign dropped    = dropped_q;
    assign busy       = busy_q;
    assign run_done   = run_done_q;

endmodule
